// File: rtl/sm4_pkg.sv
// SM4 constants shared by the key schedule and the cipher core:
// FK/CK tables, the S-box, the key-schedule state encoding and tau.
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STREAM = 2'd2
  } sm4_ks_state_e;

  localparam logic [31:0] FK [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [31:0] CK [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] sm4_tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: rk = K0 ^ L'(tau(K1^K2^K3^CK)).
module sm4_key_round
  import sm4_pkg::*;
(
  input  logic [127:0] i_k,
  input  logic [31:0]  i_ck,
  output logic [31:0]  o_rk
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_t;

  assign w_a  = i_k[95:64] ^ i_k[63:32] ^ i_k[31:0] ^ i_ck;
  assign w_b  = sm4_tau(w_a);
  assign w_t  = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
  assign o_rk = i_k[127:96] ^ w_t;

endmodule

// File: rtl/sm4_key_sched.sv
// SM4 round-key scheduler: expands MK into a 32-entry round-key cache
// (NRK rounds per clock) and streams it in encrypt or decrypt order.
module sm4_key_sched
  import sm4_pkg::*;
#(
  parameter int NRK = 1
) (
  input  logic         clk_sys,
  input  logic         sys_rst_n,
  input  logic         sm4_start,
  input  logic         sm4_mode,
  input  logic [127:0] sm4_key_in,
  input  logic         sm4_key_in_vld,
  output logic [31:0]  key2core_rkey,
  output logic         key2core_rkey_vld,
  input  logic         key2core_rkey_rdy,
  output logic [4:0]   key2core_rkey_idx,
  output logic         key2core_rkey_last,
  output logic         key_busy,
  output logic         key_cache_vld,
  output logic         key_err
);

  if (NRK != 1 && NRK != 2 && NRK != 4 && NRK != 8) begin : g_bad_nrk
    $error("sm4_key_sched: NRK must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] RND_STEP = 5'(NRK);
  localparam logic [4:0] LAST_RND = 5'(32 - NRK);

  sm4_ks_state_e r_state;
  sm4_ks_state_e w_next;

  logic [127:0] r_k;
  logic [4:0]   r_rnd;
  logic         r_mode;
  logic         r_pend;
  logic         r_cache;
  logic         r_err;
  logic         r_vld;
  logic         r_last;
  logic [31:0]  r_rkey;
  logic [4:0]   r_idx;
  logic [4:0]   r_beat;
  logic [31:0]  r_rf [32];

  logic [127:0] w_st [NRK+1];
  logic [31:0]  w_rk [NRK];

  logic       w_idle;
  logic       w_exp;
  logic       w_strm;
  logic       w_load;
  logic       w_replay;
  logic       w_err;
  logic       w_exp_done;
  logic       w_enter;
  logic       w_enter_dec;
  logic       w_xfer;
  logic [4:0] w_idx_nxt;

  // Rounds chained combinationally; each stage shifts in its new K word.
  assign w_st[0] = r_k;
  for (genvar g = 0; g < NRK; g++) begin : g_round
    sm4_key_round u_round (
      .i_k  (w_st[g]),
      .i_ck (CK[r_rnd + 5'(g)]),
      .o_rk (w_rk[g])
    );
    assign w_st[g+1] = {w_st[g][95:0], w_rk[g]};
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign w_exp       = (r_state == ST_EXPAND);
  assign w_strm      = (r_state == ST_STREAM);
  assign w_load      = w_idle & sm4_key_in_vld;
  assign w_replay    = w_idle & sm4_start & ~sm4_key_in_vld & r_cache;
  assign w_err       = (~w_idle & (sm4_start | sm4_key_in_vld)) |
                       (w_idle & sm4_start & ~sm4_key_in_vld & ~r_cache);
  assign w_exp_done  = w_exp & (r_rnd == LAST_RND);
  assign w_enter     = w_replay | (w_exp_done & r_pend);
  assign w_enter_dec = w_replay ? sm4_mode : r_mode;
  assign w_xfer      = r_vld & key2core_rkey_rdy;
  assign w_idx_nxt   = r_mode ? (r_idx - 5'd1) : (r_idx + 5'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load)        w_next = ST_EXPAND;
        else if (w_replay) w_next = ST_STREAM;
      end
      ST_EXPAND: begin
        if (w_exp_done) w_next = r_pend ? ST_STREAM : ST_IDLE;
      end
      ST_STREAM: begin
        if (w_xfer && r_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge clk_sys or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_k     <= '0;
      r_rnd   <= '0;
      r_mode  <= 1'b0;
      r_pend  <= 1'b0;
      r_cache <= 1'b0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_rkey  <= '0;
      r_idx   <= '0;
      r_beat  <= '0;
    end else begin
      r_err <= w_err;
      if (w_load) begin
        r_k     <= sm4_key_in ^ {FK[0], FK[1], FK[2], FK[3]};
        r_rnd   <= '0;
        r_mode  <= sm4_mode;
        r_pend  <= sm4_start;
        r_cache <= 1'b0;
      end else if (w_exp) begin
        r_k   <= w_st[NRK];
        r_rnd <= r_rnd + RND_STEP;
        if (w_exp_done) begin
          r_cache <= 1'b1;
          r_pend  <= 1'b0;
        end
      end else if (w_replay) begin
        r_mode <= sm4_mode;
      end
      // Stream entry spends one cycle fetching the first key from the cache.
      if (w_enter) begin
        r_idx  <= w_enter_dec ? 5'd31 : 5'd0;
        r_beat <= '0;
        r_vld  <= 1'b0;
        r_last <= 1'b0;
      end else if (w_strm) begin
        if (!r_vld) begin
          r_vld  <= 1'b1;
          r_rkey <= r_rf[r_idx];
        end else if (w_xfer) begin
          if (r_last) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
            r_rkey <= '0;
            r_idx  <= '0;
          end else begin
            r_idx  <= w_idx_nxt;
            r_rkey <= r_rf[w_idx_nxt];
            r_beat <= r_beat + 5'd1;
            r_last <= (r_beat == 5'd30);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_exp) begin
      for (int unsigned j = 0; j < NRK; j++) begin
        r_rf[r_rnd + 5'(j)] <= w_rk[j];
      end
    end
  end

  assign key2core_rkey      = r_rkey;
  assign key2core_rkey_vld  = r_vld;
  assign key2core_rkey_idx  = r_idx;
  assign key2core_rkey_last = r_last;
  assign key_busy           = ~w_idle;
  assign key_cache_vld      = r_cache;
  assign key_err            = r_err;

endmodule

// File: doc/sm4_key_sched.md
SM4_KEY_SCHED -- requirements
Module: sm4_key_sched

Interface
REQ-001 SHALL provide parameter NRK, default 1, meaning round keys computed per clock in EXPAND; legal values 1, 2, 4, 8; others rejected at elaboration.
REQ-002 SHALL provide clk_sys  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL provide sys_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide sm4_start  input  1  one-cycle request to stream a round-key sequence.
REQ-005 SHALL provide sm4_mode  input  1  sampled with sm4_start; 0 = encrypt order rk0..rk31, 1 = decrypt order rk31..rk0.
REQ-006 SHALL provide sm4_key_in  input  128  master key MK, MK0 in [127:96].
REQ-007 SHALL provide sm4_key_in_vld  input  1  sm4_key_in valid this cycle.
REQ-008 SHALL provide key2core_rkey  output  32  current round key.
REQ-009 SHALL provide key2core_rkey_vld  output  1  key2core_rkey valid.
REQ-010 SHALL provide key2core_rkey_rdy  input  1  consumer accepts the current round key.
REQ-011 SHALL provide key2core_rkey_idx  output  5  round index 0..31 of key2core_rkey.
REQ-012 SHALL provide key2core_rkey_last  output  1  high with the 32nd beat of a sequence.
REQ-013 SHALL provide key_busy  output  1  high in EXPAND or STREAM.
REQ-014 SHALL provide key_cache_vld  output  1  32 round keys stored match the last loaded key.
REQ-015 SHALL provide key_err  output  1  one-cycle pulse on a rejected request.

Function
REQ-016 SHALL implement states IDLE, EXPAND, STREAM; only IDLE accepts requests.
REQ-017 In IDLE, start=1 with key_in_vld=1 SHALL latch MK and mode, clear key_cache_vld, and enter EXPAND.
REQ-018 In IDLE, key_in_vld=1 with start=0 SHALL latch MK and enter EXPAND with no stream (precompute); IDLE follows.
REQ-019 In IDLE, start=1 with key_in_vld=0 and key_cache_vld=1 SHALL enter STREAM directly; vld rises the next cycle.
REQ-020 In IDLE, start=1 with key_in_vld=0 and key_cache_vld=0 SHALL pulse key_err next cycle and stay IDLE.
REQ-021 Any start or key_in_vld while key_busy=1 SHALL be ignored and pulse key_err next cycle; state unaffected.
REQ-022 Expansion SHALL follow GB/T 32907: K0..K3 = MK ^ FK; rk_i = K_(i+4) = K_i ^ T'(K_(i+1)^K_(i+2)^K_(i+3)^CK_i); T' = L'(tau); L'(B) = B ^ (B<<<13) ^ (B<<<23).
REQ-023 EXPAND SHALL chain NRK rounds combinationally per cycle, lasting exactly 32/NRK cycles, writing rk into a 32x32 register file.
REQ-024 On EXPAND exit key_cache_vld SHALL set; with pending stream, STREAM is entered and vld rises 32/NRK+1 edges after the request edge.
REQ-025 In STREAM a beat SHALL transfer on vld&rdy; idx advances +1 (encrypt) or -1 (decrypt) per transfer.
REQ-026 While vld=1 and rdy=0, rkey, idx and last SHALL hold stable.
REQ-027 After the transfer with last=1, vld SHALL drop next cycle and the FSM return to IDLE; a new start that cycle is accepted.
REQ-028 vld SHALL be low outside STREAM; no beat is ever dropped or repeated.

Reset
REQ-029 Asserting sys_rst_n low, including mid-EXPAND or mid-STREAM, SHALL force IDLE and drive key2core_rkey=0, vld=0, idx=0, last=0, key_busy=0, key_cache_vld=0, key_err=0.
REQ-030 Round-key register file contents SHALL need no reset; key_cache_vld gates their use.

Structure
REQ-031 A shared package sm4_pkg SHALL hold FK[0:3], CK[0:31], the 256-entry S-box and state encodings, shared with the cipher core.
REQ-032 One sub-module sm4_key_round SHALL implement one combinational round (four S-boxes, L'); NRK instances are chained.

Verification
REQ-033 NRK=1, MK=0123456789ABCDEFFEDCBA9876543210, start, mode=0, rdy=1 -> vld after 33 edges, beat0 F12186F9 idx0, beat31 9124A012 idx31 last=1.
REQ-034 Same key, NRK=4, mode=1 -> vld after 9 edges, beat0 9124A012 idx31, beat31 F12186F9 idx0 last=1.
REQ-035 Cached replay: second start, key_in_vld=0, mode=0 -> vld next cycle, identical 32-key sequence, no EXPAND.
REQ-036 rdy toggled randomly and held low 5 cycles at beat 10 -> rkey/idx stable while stalled, all 32 keys delivered in order once.
REQ-037 Start with no cache after reset -> key_err pulse, vld stays 0; start during STREAM -> key_err pulse, stream uninterrupted.
REQ-038 Reset asserted mid-STREAM at beat 15 -> outputs 0 and key_cache_vld=0 immediately; subsequent start without key -> key_err.
